intra16x16_mode_decider: RTL and testbench
==========================================

Name: intra16x16_mode_decider

Overview:
- Sits directly downstream of the 16x16 luma intra predictor.
- Consumes the original macroblock plus the vertical, horizontal and DC predictions, streamed one 16-pixel row per beat.
- Accumulates the SAD (sum of absolute differences) of each prediction mode against the original, then selects the best mode.
- Reports the winner and its cost to the encoder control / residual stage over a valid/ready handshake.

Parameters:
- PIXEL_WIDTH, 8, bits per luma sample.
- SAD_WIDTH, 16, accumulator and cost width. Must be >= PIXEL_WIDTH+8; the worst case is 256*255 = 65280.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new macroblock; sampled in IDLE only.
- top_avail  input  1  top neighbours valid; latched at start.
- left_avail  input  1  left neighbours valid; latched at start.
- row_valid  input  1  row beat valid.
- row_ready  output  1  block accepts a row beat.
- orig_row  input  16*PIXEL_WIDTH  original row; pixel i is at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- vpred_row  input  16*PIXEL_WIDTH  vertical prediction row, same packing.
- hpred_row  input  16*PIXEL_WIDTH  horizontal prediction row, same packing.
- dcpred_row  input  16*PIXEL_WIDTH  DC prediction row, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- best_mode  output  2  0 = vertical, 1 = horizontal, 2 = DC (H.264 numbering; 3 is never produced).
- best_sad  output  SAD_WIDTH  SAD of the chosen mode.

Behaviour:
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- Reset: state IDLE; row_ready=0, out_valid=0, best_mode=0, best_sad=0; accumulators and row counter cleared. Reset mid-operation abandons the macroblock with no partial result.
- IDLE:
  - row_ready=0.
  - On start=1: latch top_avail and left_avail, clear the three accumulators and the 4-bit row counter, go to ACCUM.
- ACCUM:
  - row_ready=1.
  - A beat transfers when row_valid && row_ready.
  - Per beat: each accumulator adds the sum over 16 pixels of |orig - pred| for its mode. Row SAD is computed unsigned with no rounding; max 16*255 = 4080 per row.
  - Row counter increments per beat.
  - The beat that transfers with counter=15 moves the FSM to COMPARE.
  - row_valid low: stall, with no state change.
  - start is ignored outside IDLE.
- COMPARE (one cycle, row_ready=0):
  - Candidates: vertical only if top_avail latched=1; horizontal only if left_avail latched=1; DC always.
  - Pick the minimum SAD among candidates. Ties go to the lower mode number (V > H > DC).
  - Register best_mode/best_sad, set out_valid=1, go to DONE.
  - Latency: out_valid is high starting the 2nd clk edge after the 16th row handshake edge, i.e. one cycle in COMPARE.
- DONE:
  - best_mode, best_sad and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0 next edge, go to IDLE.
  - A start presented in the same cycle as the out_ready handshake is ignored; start is only seen in IDLE.
- Width: accumulators are SAD_WIDTH and cannot overflow at the default width.

Optional Feature:
- Macro: INTRA16_SAD_DEBUG_EN.
- When defined:
  - Adds outputs sad_v, sad_h and sad_dc (SAD_WIDTH each), reflecting the final accumulator values.
  - These are registered with best_sad, held through DONE, and reset to 0.
  - Unavailable modes still report their computed SAD.
- When undefined: the ports do not exist; behaviour is otherwise identical.

Test Plan:
- Exact vertical match:
  - Stimulus: top/left avail=1; all orig=100; vpred=100, hpred=90, dcpred=95; 16 back-to-back rows.
  - Response: best_mode=0, best_sad=0; out_valid rises one cycle after COMPARE (2 edges after the 16th handshake).
- V/H tie:
  - Stimulus: orig=50; vpred=51, hpred=49, dcpred=52.
  - Response: best_mode=0 (tie with H at 256), best_sad=256. With debug on: sad_dc=512.
- Top unavailable:
  - Stimulus: top_avail=0; orig=10; vpred=10, hpred=13, dcpred=12.
  - Response: best_mode=2, best_sad=512 (vertical excluded despite SAD 0).
- Stalls:
  - Stimulus: row_valid deasserted for random 0-3 cycle gaps between rows; orig row r = r*16, dcpred=0, vpred=hpred=255.
  - Response: best_mode=2, best_sad=16*sum(r*16 for r=0..15)=30720; exactly 16 handshakes counted.
- Reset mid-block:
  - Stimulus: assert reset after 8 rows accepted; then start a fresh macroblock with orig=hpred=7, vpred=dcpred=0.
  - Response: row_ready=0 and out_valid=0 the cycle after reset; result best_mode=1, best_sad=0 (no residue from the aborted block).
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while pulsing start.
  - Response: outputs stable, start ignored. out_ready=1 gives one handshake, then IDLE with out_valid=0.

Source files
------------

// File: rtl/intra16x16_mode_decider.sv
// Intra 16x16 luma mode decider: accumulates V/H/DC SAD over 16 row beats and picks the cheapest available mode.
// Optional INTRA16_SAD_DEBUG_EN exposes the three final accumulator values as sad_v/sad_h/sad_dc.

module intra16_lane_absdiff #(
  parameter int W = 8
) (
  input  logic [W-1:0] orig_i,
  input  logic [W-1:0] v_i,
  input  logic [W-1:0] h_i,
  input  logic [W-1:0] dc_i,
  output logic [W-1:0] dv_o,
  output logic [W-1:0] dh_o,
  output logic [W-1:0] ddc_o
);
  assign dv_o  = (orig_i > v_i)  ? orig_i - v_i  : v_i  - orig_i;
  assign dh_o  = (orig_i > h_i)  ? orig_i - h_i  : h_i  - orig_i;
  assign ddc_o = (orig_i > dc_i) ? orig_i - dc_i : dc_i - orig_i;
endmodule

module intra16x16_mode_decider #(
  parameter int PIXEL_WIDTH = 8,
  parameter int SAD_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      top_avail,
  input  logic                      left_avail,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [16*PIXEL_WIDTH-1:0] orig_row,
  input  logic [16*PIXEL_WIDTH-1:0] vpred_row,
  input  logic [16*PIXEL_WIDTH-1:0] hpred_row,
  input  logic [16*PIXEL_WIDTH-1:0] dcpred_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                best_mode,
  output logic [SAD_WIDTH-1:0]      best_sad
`ifdef INTRA16_SAD_DEBUG_EN
  ,
  output logic [SAD_WIDTH-1:0]      sad_v,
  output logic [SAD_WIDTH-1:0]      sad_h,
  output logic [SAD_WIDTH-1:0]      sad_dc
`endif
);
  localparam int NUM_LANES = 16;
  localparam int ROW_W     = PIXEL_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   top_q, left_q;
  logic [SAD_WIDTH-1:0]   acc_v_q, acc_h_q, acc_dc_q;
  logic                   row_ready_q, out_valid_q;
  logic [1:0]             mode_q;
  logic [SAD_WIDTH-1:0]   sad_q;
`ifdef INTRA16_SAD_DEBUG_EN
  logic [SAD_WIDTH-1:0]   dbg_v_q, dbg_h_q, dbg_dc_q;
`endif

  logic [NUM_LANES-1:0][PIXEL_WIDTH-1:0] ad_v, ad_h, ad_dc;
  logic [ROW_W-1:0]       rsum_v, rsum_h, rsum_dc;
  logic [1:0]             mode_d;
  logic [SAD_WIDTH-1:0]   sad_d;
  logic                   beat;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      intra16_lane_absdiff #(.W(PIXEL_WIDTH)) u_ad (
        .orig_i (orig_row  [g*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .v_i    (vpred_row [g*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .h_i    (hpred_row [g*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .dc_i   (dcpred_row[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .dv_o   (ad_v[g]),
        .dh_o   (ad_h[g]),
        .ddc_o  (ad_dc[g])
      );
    end
  endgenerate

  always_comb begin
    rsum_v  = '0;
    rsum_h  = '0;
    rsum_dc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rsum_v  = rsum_v  + ROW_W'(ad_v[i]);
      rsum_h  = rsum_h  + ROW_W'(ad_h[i]);
      rsum_dc = rsum_dc + ROW_W'(ad_dc[i]);
    end
  end

  // DC is always a candidate; H then V override on <=, so ties favour the lower mode number.
  always_comb begin
    mode_d = 2'd2;
    sad_d  = acc_dc_q;
    if (left_q && (acc_h_q <= sad_d)) begin
      mode_d = 2'd1;
      sad_d  = acc_h_q;
    end
    if (top_q && (acc_v_q <= sad_d)) begin
      mode_d = 2'd0;
      sad_d  = acc_v_q;
    end
  end

  assign beat = row_valid && row_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      top_q       <= 1'b0;
      left_q      <= 1'b0;
      acc_v_q     <= '0;
      acc_h_q     <= '0;
      acc_dc_q    <= '0;
      row_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= '0;
      sad_q       <= '0;
`ifdef INTRA16_SAD_DEBUG_EN
      dbg_v_q     <= '0;
      dbg_h_q     <= '0;
      dbg_dc_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            top_q       <= top_avail;
            left_q      <= left_avail;
            acc_v_q     <= '0;
            acc_h_q     <= '0;
            acc_dc_q    <= '0;
            cnt_q       <= '0;
            row_ready_q <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_v_q  <= acc_v_q  + SAD_WIDTH'(rsum_v);
            acc_h_q  <= acc_h_q  + SAD_WIDTH'(rsum_h);
            acc_dc_q <= acc_dc_q + SAD_WIDTH'(rsum_dc);
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              row_ready_q <= 1'b0;
              state_q     <= COMPARE;
            end
          end
        end
        COMPARE: begin
          mode_q      <= mode_d;
          sad_q       <= sad_d;
`ifdef INTRA16_SAD_DEBUG_EN
          dbg_v_q     <= acc_v_q;
          dbg_h_q     <= acc_h_q;
          dbg_dc_q    <= acc_dc_q;
`endif
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_ready = row_ready_q;
  assign out_valid = out_valid_q;
  assign best_mode = mode_q;
  assign best_sad  = sad_q;
`ifdef INTRA16_SAD_DEBUG_EN
  assign sad_v  = dbg_v_q;
  assign sad_h  = dbg_h_q;
  assign sad_dc = dbg_dc_q;
`endif

endmodule

// File: tb/tb_intra16x16_mode_decider.sv
// Randomised bench for intra16x16_mode_decider with an array-based SAD/mode reference model.
module tb_intra16x16_mode_decider;
  localparam int PW = 8;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset, start, top_avail, left_avail, row_valid, out_ready;
  logic row_ready, out_valid;
  logic [1:0] best_mode;
  logic [SW-1:0] best_sad;
  logic [16*PW-1:0] orig_row, vpred_row, hpred_row, dcpred_row;
`ifdef INTRA16_SAD_DEBUG_EN
  logic [SW-1:0] sad_v, sad_h, sad_dc;
`endif

  intra16x16_mode_decider #(.PIXEL_WIDTH(PW), .SAD_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .top_avail(top_avail), .left_avail(left_avail),
    .row_valid(row_valid), .row_ready(row_ready), .orig_row(orig_row), .vpred_row(vpred_row),
    .hpred_row(hpred_row), .dcpred_row(dcpred_row), .out_valid(out_valid), .out_ready(out_ready),
    .best_mode(best_mode), .best_sad(best_sad)
`ifdef INTRA16_SAD_DEBUG_EN
    , .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc)
`endif
  );

  always #5 clk = ~clk;

  int orig_a[16][16], vp_a[16][16], hp_a[16][16], dp_a[16][16];
  int n_chk = 0, n_pass = 0;
  int exp_mode, exp_sad, exp_v, exp_h, exp_dc;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Reference: total |orig-pred| per mode, then cheapest available candidate; candidates are
  // visited in mode-number order and only a strictly lower cost displaces the incumbent.
  task automatic model(input bit top, input bit left);
    int cost[3];
    bit avail[3];
    int best;
    cost = '{0, 0, 0};
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) begin
        cost[0] += (orig_a[r][p] > vp_a[r][p]) ? orig_a[r][p] - vp_a[r][p] : vp_a[r][p] - orig_a[r][p];
        cost[1] += (orig_a[r][p] > hp_a[r][p]) ? orig_a[r][p] - hp_a[r][p] : hp_a[r][p] - orig_a[r][p];
        cost[2] += (orig_a[r][p] > dp_a[r][p]) ? orig_a[r][p] - dp_a[r][p] : dp_a[r][p] - orig_a[r][p];
      end
    avail = '{top, left, 1'b1};
    best = -1;
    for (int m = 0; m < 3; m++)
      if (avail[m] && (best < 0 || cost[m] < cost[best])) best = m;
    exp_mode = best;
    exp_sad  = cost[best];
    exp_v = cost[0]; exp_h = cost[1]; exp_dc = cost[2];
  endtask

  task automatic fill(input int o, input int v, input int h, input int d);
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) begin
        orig_a[r][p] = o; vp_a[r][p] = v; hp_a[r][p] = h; dp_a[r][p] = d;
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) begin
        orig_a[r][p] = $urandom_range(0, 255);
        vp_a[r][p] = $urandom_range(0, 255);
        hp_a[r][p] = $urandom_range(0, 255);
        dp_a[r][p] = $urandom_range(0, 255);
      end
  endtask

  task automatic drive_row(input int r);
    for (int p = 0; p < 16; p++) begin
      orig_row[p*PW +: PW]   = PW'(orig_a[r][p]);
      vpred_row[p*PW +: PW]  = PW'(vp_a[r][p]);
      hpred_row[p*PW +: PW]  = PW'(hp_a[r][p]);
      dcpred_row[p*PW +: PW] = PW'(dp_a[r][p]);
    end
  endtask

  // Sends start then rows; returns after nrows handshakes (or a cycle budget).
  task automatic send_rows(input bit top, input bit left, input int nrows, input int maxgap, output int hs);
    int r, guard;
    bit xfer;
    top_avail = top; left_avail = left; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("row_ready_in_accum", int'(row_ready), 1);
    r = 0; hs = 0; guard = 0;
    while (r < nrows && guard < 400) begin
      row_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(negedge clk); guard++; end
      drive_row(r);
      row_valid = 1'b1;
      xfer = row_ready;
      @(negedge clk);
      guard++;
      if (xfer) begin hs++; r++; end
    end
    row_valid = 1'b0;
    if (r < nrows) check("row_handshake_timeout", r, nrows);
  endtask

  task automatic run_block(input bit top, input bit left, input int maxgap, input int hold, output int hs);
    model(top, left);
    chk_en = 1'b1;
    send_rows(top, left, 16, maxgap, hs);
    check("out_valid_low_in_compare", int'(out_valid), 0);
    check("row_ready_low_after_16", int'(row_ready), 0);
    @(negedge clk);
    check("out_valid_latency", int'(out_valid), 1);
    for (int i = 0; i < hold; i++) begin
      start = i[0];
      @(negedge clk);
      check("out_valid_held", int'(out_valid), 1);
    end
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk_en = 1'b0;
    check("out_valid_after_accept", int'(out_valid), 0);
    @(negedge clk);
    check("idle_ignores_handshake_start", int'(row_ready), 0);
  endtask

  // Compares every cycle the result is presented.
  always @(negedge clk) begin
    if (chk_en && out_valid) begin
      check("best_mode", int'(best_mode), exp_mode);
      check("best_sad", int'(best_sad), exp_sad);
`ifdef INTRA16_SAD_DEBUG_EN
      check("sad_v", int'(sad_v), exp_v);
      check("sad_h", int'(sad_h), exp_h);
      check("sad_dc", int'(sad_dc), exp_dc);
`endif
    end
  end

  initial begin
    int hs;
    reset = 1'b1; start = 1'b0; top_avail = 1'b0; left_avail = 1'b0;
    row_valid = 1'b0; out_ready = 1'b0;
    orig_row = '0; vpred_row = '0; hpred_row = '0; dcpred_row = '0;
    repeat (2) @(negedge clk);
    check("reset_row_ready", int'(row_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_best_mode", int'(best_mode), 0);
    check("reset_best_sad", int'(best_sad), 0);
    reset = 1'b0;
    @(negedge clk);

    // exact vertical match, with backpressure and start pulses in DONE
    fill(100, 100, 90, 95);
    model(1, 1);
    check("model_vmatch_mode", exp_mode, 0);
    check("model_vmatch_sad", exp_sad, 0);
    run_block(1, 1, 0, 5, hs);

    // V/H tie
    fill(50, 51, 49, 52);
    model(1, 1);
    check("model_tie_mode", exp_mode, 0);
    check("model_tie_sad", exp_sad, 256);
    check("model_tie_dc", exp_dc, 512);
    run_block(1, 1, 0, 1, hs);

    // top unavailable
    fill(10, 10, 13, 12);
    model(0, 1);
    check("model_notop_mode", exp_mode, 2);
    check("model_notop_sad", exp_sad, 512);
    run_block(0, 1, 0, 0, hs);

    // stalls between rows
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) begin
        orig_a[r][p] = r * 16; dp_a[r][p] = 0; vp_a[r][p] = 255; hp_a[r][p] = 255;
      end
    model(1, 1);
    check("model_stall_mode", exp_mode, 2);
    check("model_stall_sad", exp_sad, 30720);
    run_block(1, 1, 3, 2, hs);
    check("stall_handshakes", hs, 16);

    // reset mid-block
    fill_rand();
    send_rows(1, 1, 8, 1, hs);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_row_ready", int'(row_ready), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_best_sad", int'(best_sad), 0);
    reset = 1'b0;
    @(negedge clk);
    fill(7, 0, 7, 0);
    model(1, 1);
    check("model_fresh_mode", exp_mode, 1);
    check("model_fresh_sad", exp_sad, 0);
    run_block(1, 1, 1, 0, hs);

    // random macroblocks
    for (int b = 0; b < 8; b++) begin
      bit t, l;
      fill_rand();
      t = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      run_block(t, l, 2, $urandom_range(0, 3), hs);
      check("rand_handshakes", hs, 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, required completion", n_chk);
    $fatal(1, "timeout");
  end
endmodule
